// File: rtl/pipeline_controller.sv
// Pipelined MIPS control unit: D-stage decode plus D/E, E/M and M/W control registers.
// Each stage's datapath controls come straight from that stage's register.
module pipeline_controller #(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   Opcode,
    input  logic [OPW-1:0]   Funct,
    input  logic             EqualD,
    input  logic             FlushE,
    output logic             BranchD,
    output logic             JumpD,
    output logic             PCSrcD,
    output logic             IllegalOpD,
    output logic             RegDstE,
    output logic             ALUSrcE,
    output logic [ALUCW-1:0] ALUControlE,
    output logic             RegWriteE,
    output logic             MemToRegE,
    output logic             RegWriteM,
    output logic             MemToRegM,
    output logic             MemWriteM,
    output logic             RegWriteW,
    output logic             MemToRegW
);

    typedef enum logic [OPW-1:0] {
        OP_RTYPE = OPW'(6'b000000),
        OP_J     = OPW'(6'b000010),
        OP_BEQ   = OPW'(6'b000100),
        OP_ADDI  = OPW'(6'b001000),
        OP_LW    = OPW'(6'b100011),
        OP_SW    = OPW'(6'b101011)
    } opcode_e;

    typedef enum logic [OPW-1:0] {
        FN_ADD = OPW'(6'b100000),
        FN_SUB = OPW'(6'b100010),
        FN_AND = OPW'(6'b100100),
        FN_OR  = OPW'(6'b100101),
        FN_SLT = OPW'(6'b101010)
    } funct_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [ALUCW-1:0] {
        ALU_AND = ALUCW'(3'b000),
        ALU_OR  = ALUCW'(3'b001),
        ALU_ADD = ALUCW'(3'b010),
        ALU_SUB = ALUCW'(3'b110),
        ALU_SLT = ALUCW'(3'b111)
    } aluctl_e;

    logic    w_regwrite_raw;
    logic    w_regwrite;
    logic    w_regdst;
    logic    w_alusrc;
    logic    w_branch;
    logic    w_memwrite;
    logic    w_memtoreg;
    logic    w_jump;
    logic    w_illegal_op;
    logic    w_illegal_funct;
    aluop_e  w_aluop;
    aluctl_e w_alucontrol;

    logic             r_regwrite_e;
    logic             r_memtoreg_e;
    logic             r_memwrite_e;
    logic [ALUCW-1:0] r_alucontrol_e;
    logic             r_alusrc_e;
    logic             r_regdst_e;
    logic             r_regwrite_m;
    logic             r_memtoreg_m;
    logic             r_memwrite_m;
    logic             r_regwrite_w;
    logic             r_memtoreg_w;

    always_comb begin
        w_regwrite_raw = 1'b0;
        w_regdst       = 1'b0;
        w_alusrc       = 1'b0;
        w_branch       = 1'b0;
        w_memwrite     = 1'b0;
        w_memtoreg     = 1'b0;
        w_jump         = 1'b0;
        w_aluop        = ALUOP_ADD;
        w_illegal_op   = 1'b0;
        case (Opcode)
            OP_RTYPE: begin
                w_regwrite_raw = 1'b1;
                w_regdst       = 1'b1;
                w_aluop        = ALUOP_FUNCT;
            end
            OP_LW: begin
                w_regwrite_raw = 1'b1;
                w_alusrc       = 1'b1;
                w_memtoreg     = 1'b1;
            end
            OP_SW: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_branch = 1'b1;
                w_aluop  = ALUOP_SUB;
            end
            OP_ADDI: begin
                w_regwrite_raw = 1'b1;
                w_alusrc       = 1'b1;
            end
            OP_J:    w_jump       = 1'b1;
            default: w_illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        w_alucontrol    = ALU_ADD;
        w_illegal_funct = 1'b0;
        case (w_aluop)
            ALUOP_SUB: w_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  w_alucontrol    = ALU_ADD;
                    FN_SUB:  w_alucontrol    = ALU_SUB;
                    FN_AND:  w_alucontrol    = ALU_AND;
                    FN_OR:   w_alucontrol    = ALU_OR;
                    FN_SLT:  w_alucontrol    = ALU_SLT;
                    default: w_illegal_funct = 1'b1;
                endcase
            end
            default: w_alucontrol = ALU_ADD;
        endcase
    end

    // An unknown R-type funct must never commit a register write.
    assign w_regwrite = w_regwrite_raw & ~w_illegal_funct;

    assign BranchD    = w_branch;
    assign JumpD      = w_jump;
    assign PCSrcD     = w_branch & EqualD;
    assign IllegalOpD = w_illegal_op | w_illegal_funct;

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_regwrite_e   <= 1'b0;
            r_memtoreg_e   <= 1'b0;
            r_memwrite_e   <= 1'b0;
            r_alucontrol_e <= '0;
            r_alusrc_e     <= 1'b0;
            r_regdst_e     <= 1'b0;
        end else begin
            r_regwrite_e   <= w_regwrite;
            r_memtoreg_e   <= w_memtoreg;
            r_memwrite_e   <= w_memwrite;
            r_alucontrol_e <= w_alucontrol;
            r_alusrc_e     <= w_alusrc;
            r_regdst_e     <= w_regdst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= 1'b0;
            r_regwrite_w <= 1'b0;
            r_memtoreg_w <= 1'b0;
        end else begin
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_memwrite_m <= r_memwrite_e;
            r_regwrite_w <= r_regwrite_m;
            r_memtoreg_w <= r_memtoreg_m;
        end
    end

    assign RegDstE     = r_regdst_e;
    assign ALUSrcE     = r_alusrc_e;
    assign ALUControlE = r_alucontrol_e;
    assign RegWriteE   = r_regwrite_e;
    assign MemToRegE   = r_memtoreg_e;
    assign RegWriteM   = r_regwrite_m;
    assign MemToRegM   = r_memtoreg_m;
    assign MemWriteM   = r_memwrite_m;
    assign RegWriteW   = r_regwrite_w;
    assign MemToRegW   = r_memtoreg_w;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a table-driven decode model.
module tb_pipeline_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       EqualD;
    logic       FlushE;
    logic       BranchD, JumpD, PCSrcD, IllegalOpD;
    logic       RegDstE, ALUSrcE, RegWriteE, MemToRegE;
    logic [2:0] ALUControlE;
    logic       RegWriteM, MemToRegM, MemWriteM, RegWriteW, MemToRegW;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_controller #(.OPW(6), .ALUCW(3)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .EqualD(EqualD), .FlushE(FlushE),
        .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD), .IllegalOpD(IllegalOpD),
        .RegDstE(RegDstE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW)
    );

    typedef struct packed {
        logic       rw, rdst, asrc, br, mw, mtr, jmp, ill;
        logic [2:0] aluc;
    } dec_t;

    // Straight transcription of the instruction table.
    function automatic dec_t ref_decode(logic [5:0] op, logic [5:0] fn);
        dec_t d = '0;
        d.aluc = 3'b010;
        case (op)
            6'b000000: begin
                d.rw = 1'b1; d.rdst = 1'b1;
                case (fn)
                    6'b100000: d.aluc = 3'b010;
                    6'b100010: d.aluc = 3'b110;
                    6'b100100: d.aluc = 3'b000;
                    6'b100101: d.aluc = 3'b001;
                    6'b101010: d.aluc = 3'b111;
                    default: begin d.rw = 1'b0; d.ill = 1'b1; end
                endcase
            end
            6'b100011: begin d.rw = 1'b1; d.asrc = 1'b1; d.mtr = 1'b1; end
            6'b101011: begin d.asrc = 1'b1; d.mw = 1'b1; end
            6'b000100: begin d.br = 1'b1; d.aluc = 3'b110; end
            6'b001000: begin d.rw = 1'b1; d.asrc = 1'b1; end
            6'b000010: d.jmp = 1'b1;
            default:   d.ill = 1'b1;
        endcase
        return d;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: ages of in-flight control words, index 0 = E, 1 = M, 2 = W.
    dec_t pipe[3];
    bit   model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            model_valid = 1'b1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = FlushE ? dec_t'('0) : ref_decode(Opcode, Funct);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            dec_t d;
            d = ref_decode(Opcode, Funct);
            chk("BranchD",     {7'd0, BranchD},    {7'd0, d.br});
            chk("JumpD",       {7'd0, JumpD},      {7'd0, d.jmp});
            chk("PCSrcD",      {7'd0, PCSrcD},     {7'd0, d.br & EqualD});
            chk("IllegalOpD",  {7'd0, IllegalOpD}, {7'd0, d.ill});
            chk("RegDstE",     {7'd0, RegDstE},    {7'd0, pipe[0].rdst});
            chk("ALUSrcE",     {7'd0, ALUSrcE},    {7'd0, pipe[0].asrc});
            chk("ALUControlE", {5'd0, ALUControlE}, {5'd0, pipe[0].aluc});
            chk("RegWriteE",   {7'd0, RegWriteE},  {7'd0, pipe[0].rw});
            chk("MemToRegE",   {7'd0, MemToRegE},  {7'd0, pipe[0].mtr});
            chk("RegWriteM",   {7'd0, RegWriteM},  {7'd0, pipe[1].rw});
            chk("MemToRegM",   {7'd0, MemToRegM},  {7'd0, pipe[1].mtr});
            chk("MemWriteM",   {7'd0, MemWriteM},  {7'd0, pipe[1].mw});
            chk("RegWriteW",   {7'd0, RegWriteW},  {7'd0, pipe[2].rw});
            chk("MemToRegW",   {7'd0, MemToRegW},  {7'd0, pipe[2].mtr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [5:0] op, input logic [5:0] fn);
        Opcode = op;
        Funct  = fn;
    endtask

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    logic [5:0] rfn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] rctl[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [5:0] ops [6] = '{RT, LW, SW, BEQ, ADDI, J};

    initial begin
        reset = 1'b1; FlushE = 1'b0; EqualD = 1'b0;
        put(LW, 6'd0);
        tick(); tick();
        chk("reset_regs", {MemWriteM, RegWriteW, MemToRegW, RegWriteM, MemToRegM,
                           RegWriteE, MemToRegE, ALUSrcE}, 8'h00);
        reset = 1'b0;
        tick();
        chk("lw_E", {MemToRegE, RegWriteE, ALUSrcE, RegDstE, 1'b0, ALUControlE}, 8'b1110_0010);

        foreach (rfn[i]) begin
            put(RT, rfn[i]);
            tick();
            chk("rtype_aluc", {5'd0, ALUControlE}, {5'd0, rctl[i]});
            chk("rtype_rdst", {7'd0, RegDstE}, 8'd1);
        end
        put(BEQ, 6'd0);
        tick(); tick();
        chk("rtype_W", {7'd0, RegWriteW}, 8'd1);

        put(SW, 6'd0);  tick();
        put(LW, 6'd0);  tick();
        chk("sw_M", {7'd0, MemWriteM}, 8'd1);
        put(BEQ, 6'd0); tick();
        chk("sw_M_once", {7'd0, MemWriteM}, 8'd0);
        tick();
        chk("lw_W", {7'd0, MemToRegW}, 8'd1);

        put(BEQ, 6'd0); EqualD = 1'b1; #1;
        chk("pcsrc_taken", {7'd0, PCSrcD}, 8'd1);
        EqualD = 1'b0; #1;
        chk("pcsrc_not", {7'd0, PCSrcD}, 8'd0);
        tick();
        chk("beq_E", {RegWriteE, 4'd0, ALUControlE}, 8'b0000_0110);

        put(RT, 6'b100000); tick();
        put(ADDI, 6'd0); FlushE = 1'b1; tick();
        FlushE = 1'b0; put(BEQ, 6'd0);
        chk("flush_E", {6'd0, RegWriteE, ALUSrcE}, 8'd0);
        tick();
        chk("flush_M", {6'd0, RegWriteM, RegWriteW}, 8'b01);
        tick();
        chk("flush_W", {7'd0, RegWriteW}, 8'd0);

        put(6'b111111, 6'd0); #1;
        chk("illegal_op", {7'd0, IllegalOpD}, 8'd1);
        tick();
        put(RT, 6'b000111); #1;
        chk("illegal_fn", {7'd0, IllegalOpD}, 8'd1);
        tick();
        put(SW, 6'd0); tick();
        put(LW, 6'd0); reset = 1'b1; tick();
        chk("reset_mid", {6'd0, MemWriteM, RegWriteW}, 8'd0);
        reset = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) < 8) put(ops[$urandom_range(0, 5)], 6'($urandom));
            else                          put(6'($urandom), 6'($urandom));
            if (Opcode == RT && $urandom_range(0, 3) != 0) Funct = rfn[$urandom_range(0, 4)];
            EqualD = 1'($urandom);
            FlushE = ($urandom_range(0, 99) < 15);
            reset  = ($urandom_range(0, 99) < 3);
            tick();
        end
        reset = 1'b0; FlushE = 1'b0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
